// File: rtl/nv_ram_fifo_ctrl_19x32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nv_ram_fifo_ctrl_19x32: valid/ready FIFO sequencing a 19x32 two-port RAM |
// | whose output register serves as the head slot (20 entries in total).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nv_ram_fifo_ctrl_19x32 #(
  parameter int DEPTH     = 19,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW:0]   fifo_cnt,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  output logic          ram_ore,
  output logic          ram_byp_sel,
  output logic [DW-1:0] ram_dbyp,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW-1:0] c_adr_last = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_adr_one  = AW'(1);
  localparam logic [AW:0]   c_depth    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one  = (AW + 1)'(1);
  localparam logic          c_byp_en   = (BYPASS_EN != 0);

  logic [AW-1:0] wr_adr_q, wr_adr_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic [AW:0]   unis_cnt_q, unis_cnt_d;
  logic          p1_vld_q, p1_vld_d;
  logic          out_vld_q, out_vld_d;

  logic w_push, w_pop, w_byp, w_ram_push, w_adv, w_issue;

  always_comb begin
    w_push     = wr_pvld && wr_prdy;
    w_pop      = out_vld_q && rd_prdy;
    // ram_cnt==0 guarantees nothing is in flight, so bypass never races an advance
    w_byp      = w_push && c_byp_en && (ram_cnt_q == '0) && (!out_vld_q || w_pop);
    w_ram_push = w_push && !w_byp;
    w_adv      = p1_vld_q && (!out_vld_q || w_pop);
    w_issue    = (unis_cnt_q != '0) && (!p1_vld_q || w_adv);
  end

  always_comb begin
    wr_adr_d   = wr_adr_q;
    rd_adr_d   = rd_adr_q;
    ram_cnt_d  = ram_cnt_q;
    unis_cnt_d = unis_cnt_q;
    p1_vld_d   = p1_vld_q;
    out_vld_d  = out_vld_q;

    if (w_ram_push) begin
      wr_adr_d = (wr_adr_q == c_adr_last) ? '0 : wr_adr_q + c_adr_one;
    end
    if (w_issue) begin
      rd_adr_d = (rd_adr_q == c_adr_last) ? '0 : rd_adr_q + c_adr_one;
    end

    if (w_ram_push && !w_adv) begin
      ram_cnt_d = ram_cnt_q + c_cnt_one;
    end else if (!w_ram_push && w_adv) begin
      ram_cnt_d = ram_cnt_q - c_cnt_one;
    end

    if (w_ram_push && !w_issue) begin
      unis_cnt_d = unis_cnt_q + c_cnt_one;
    end else if (!w_ram_push && w_issue) begin
      unis_cnt_d = unis_cnt_q - c_cnt_one;
    end

    if (w_issue) begin
      p1_vld_d = 1'b1;
    end else if (w_adv) begin
      p1_vld_d = 1'b0;
    end

    if (w_byp || w_adv) begin
      out_vld_d = 1'b1;
    end else if (w_pop) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_adr_q   <= '0;
      rd_adr_q   <= '0;
      ram_cnt_q  <= '0;
      unis_cnt_q <= '0;
      p1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      wr_adr_q   <= wr_adr_d;
      rd_adr_q   <= rd_adr_d;
      ram_cnt_q  <= ram_cnt_d;
      unis_cnt_q <= unis_cnt_d;
      p1_vld_q   <= p1_vld_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign wr_prdy     = !rst && (ram_cnt_q < c_depth);
  assign rd_pvld     = out_vld_q;
  assign rd_pd       = ram_dout;
  assign fifo_cnt    = ram_cnt_q + {{AW{1'b0}}, out_vld_q};
  assign ram_we      = w_ram_push;
  assign ram_wa      = wr_adr_q;
  assign ram_di      = wr_pd;
  assign ram_re      = w_issue;
  assign ram_ra      = rd_adr_q;
  assign ram_ore     = w_byp || w_adv;
  assign ram_byp_sel = w_byp;
  assign ram_dbyp    = wr_pd;

endmodule
`default_nettype wire
